secded_link_array: RTL and testbench

- Parametrised, multi-channel successor to the 4-channel Hamming(7,4) router/inject/correct chain.
- Each of NUM_CH 4-bit lanes is encoded to an 8-bit SECDED codeword (Hamming(7,4) plus overall parity).
- Each codeword passes through a programmable fault-injection stage, then a LINK_DEPTH-deep register link, then a decoder.
- The decoder corrects single errors, flags double errors, and keeps saturating error statistics.
- The block sits between the secure router outputs and the display/consumer logic, with a valid-qualified pipeline.

---
 rtl/secded_pkg.sv | 41 ++++
 rtl/secded84_dec.sv | 39 +++
 rtl/secded_link_array.sv | 197 +++++++++++++++++++
 tb/tb_secded_link_array.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED(8,4) link array.
// Contents: codeword/data widths, injection-mode enum, Hamming bit positions,
// and the secded84_enc encoder function (4 data bits -> 8-bit codeword).
package secded_pkg;

  localparam int unsigned CW_W   = 8;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'd0,
    INJ_SINGLE = 2'd1,
    INJ_DOUBLE = 2'd2,
    INJ_RSVD   = 2'd3
  } inj_mode_e;

  // Codeword bit index equals Hamming position; bit 0 holds overall parity.
  localparam int unsigned P0_POS = 0;
  localparam int unsigned P1_POS = 1;
  localparam int unsigned P2_POS = 2;
  localparam int unsigned D0_POS = 3;
  localparam int unsigned P4_POS = 4;
  localparam int unsigned D1_POS = 5;
  localparam int unsigned D2_POS = 6;
  localparam int unsigned D3_POS = 7;

  function automatic logic [CW_W-1:0] secded84_enc(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw         = '0;
    cw[D0_POS] = d[0];
    cw[D1_POS] = d[1];
    cw[D2_POS] = d[2];
    cw[D3_POS] = d[3];
    cw[P1_POS] = d[0] ^ d[1] ^ d[3];
    cw[P2_POS] = d[0] ^ d[2] ^ d[3];
    cw[P4_POS] = d[1] ^ d[2] ^ d[3];
    // Even overall parity across the whole word.
    cw[P0_POS] = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/secded84_dec.sv
// Combinational SECDED(8,4) decoder for one lane.
// Ports:
//   i_cw   - received 8-bit codeword (bit index = Hamming position)
//   o_data - corrected data (raw data bits on a double error)
//   o_sec  - single error detected and corrected
//   o_ded  - double error detected, data left uncorrected
module secded84_dec
  import secded_pkg::*;
(
  input  logic [CW_W-1:0]   i_cw,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sec,
  output logic              o_ded
);

  logic [2:0]      w_syn;
  logic            w_par;
  logic [CW_W-1:0] w_fixed;

  always_comb begin
    // Each syndrome bit covers the positions whose index has that bit set.
    w_syn   = {^(i_cw & 8'hF0), ^(i_cw & 8'hCC), ^(i_cw & 8'hAA)};
    w_par   = ^i_cw;
    w_fixed = i_cw;
    o_sec   = 1'b0;
    o_ded   = 1'b0;
    if (w_par) begin
      // Odd parity: single error. Syndrome 0 means pos0 itself flipped.
      o_sec = 1'b1;
      if (w_syn != 3'd0) begin
        w_fixed[w_syn] = ~i_cw[w_syn];
      end
    end else if (w_syn != 3'd0) begin
      o_ded = 1'b1;
    end
    o_data = {w_fixed[D3_POS], w_fixed[D2_POS], w_fixed[D1_POS], w_fixed[D0_POS]};
  end

endmodule

// File: rtl/secded_link_array.sv
// Multi-lane SECDED encode -> fault inject -> register link -> decode pipeline.
// Ports:
//   clk, rst             - clock, async active-high reset
//   valid_in, data_in    - input word, NUM_CH packed 4-bit lanes
//   inj_mode, inj_mask   - injection mode and per-lane enable
//   inj_pos0, inj_pos1   - codeword bits to flip
//   clr_cnt              - synchronous clear of both error counters
//   valid_out, data_out  - corrected output word
//   sec_flag, ded_flag   - per-lane corrected / uncorrectable flags
//   corr_cnt, uncorr_cnt - saturating error totals
// Latency valid_in -> valid_out is LINK_DEPTH+3 cycles, one word per cycle.
module secded_link_array
  import secded_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned LINK_DEPTH = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [1:0]               inj_mode,
  input  logic [NUM_CH-1:0]        inj_mask,
  input  logic [2:0]               inj_pos0,
  input  logic [2:0]               inj_pos1,
  input  logic                     clr_cnt,
  output logic                     valid_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        sec_flag,
  output logic [NUM_CH-1:0]        ded_flag,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt
);

  localparam int unsigned SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

  // Stage 1: encode, with inject controls travelling alongside the word.
  logic [NUM_CH*CW_W-1:0] w_enc_cw;
  logic [NUM_CH*CW_W-1:0] r_s1_cw;
  logic                   r_s1_valid;
  inj_mode_e              r_s1_mode;
  logic [NUM_CH-1:0]      r_s1_mask;
  logic [2:0]             r_s1_pos0;
  logic [2:0]             r_s1_pos1;

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_enc_cw[k*CW_W +: CW_W] = secded84_enc(data_in[k*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_cw    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_mode  <= INJ_NONE;
      r_s1_mask  <= '0;
      r_s1_pos0  <= '0;
      r_s1_pos1  <= '0;
    end else begin
      r_s1_cw    <= w_enc_cw;
      r_s1_valid <= valid_in;
      r_s1_mode  <= inj_mode_e'(inj_mode);
      r_s1_mask  <= inj_mask;
      r_s1_pos0  <= inj_pos0;
      r_s1_pos1  <= inj_pos1;
    end
  end

  // Stage 2: fault injection. Flipping the same bit twice cancels out.
  logic [CW_W-1:0]        w_flip0;
  logic [CW_W-1:0]        w_flip1;
  logic [NUM_CH*CW_W-1:0] w_inj_cw;

  always_comb begin
    w_flip0  = CW_W'(1) << r_s1_pos0;
    w_flip1  = CW_W'(1) << r_s1_pos1;
    w_inj_cw = r_s1_cw;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (r_s1_valid && r_s1_mask[k]) begin
        case (r_s1_mode)
          INJ_SINGLE: w_inj_cw[k*CW_W +: CW_W] = r_s1_cw[k*CW_W +: CW_W] ^ w_flip0;
          INJ_DOUBLE: w_inj_cw[k*CW_W +: CW_W] = r_s1_cw[k*CW_W +: CW_W] ^ w_flip0 ^ w_flip1;
          default:    w_inj_cw[k*CW_W +: CW_W] = r_s1_cw[k*CW_W +: CW_W];
        endcase
      end
    end
  end

  // Slot 0 is the inject register; slots 1..LINK_DEPTH form the link.
  logic [NUM_CH*CW_W-1:0] r_pipe_cw [LINK_DEPTH+1];
  logic [LINK_DEPTH:0]    r_pipe_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= LINK_DEPTH; i++) begin
        r_pipe_cw[i] <= '0;
      end
      r_pipe_valid <= '0;
    end else begin
      r_pipe_cw[0]    <= w_inj_cw;
      r_pipe_valid[0] <= r_s1_valid;
      for (int unsigned i = 1; i <= LINK_DEPTH; i++) begin
        r_pipe_cw[i]    <= r_pipe_cw[i-1];
        r_pipe_valid[i] <= r_pipe_valid[i-1];
      end
    end
  end

  // Stage 3: per-lane decode, then registered outputs and counters.
  logic                     w_dec_valid;
  logic [NUM_CH*DATA_W-1:0] w_dec_data;
  logic [NUM_CH-1:0]        w_dec_sec;
  logic [NUM_CH-1:0]        w_dec_ded;

  assign w_dec_valid = r_pipe_valid[LINK_DEPTH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    secded84_dec u_dec (
      .i_cw   (r_pipe_cw[LINK_DEPTH][g*CW_W +: CW_W]),
      .o_data (w_dec_data[g*DATA_W +: DATA_W]),
      .o_sec  (w_dec_sec[g]),
      .o_ded  (w_dec_ded[g])
    );
  end

  logic                     r_out_valid;
  logic [NUM_CH*DATA_W-1:0] r_data_out;
  logic [NUM_CH-1:0]        r_sec;
  logic [NUM_CH-1:0]        r_ded;
  logic [CNT_W-1:0]         r_corr_cnt;
  logic [CNT_W-1:0]         r_uncorr_cnt;

  logic [SUM_W-1:0] w_sec_pop;
  logic [SUM_W-1:0] w_ded_pop;
  logic [SUM_W-1:0] w_corr_sum;
  logic [SUM_W-1:0] w_uncorr_sum;
  logic [CNT_W-1:0] w_corr_nxt;
  logic [CNT_W-1:0] w_uncorr_nxt;

  // Counters advance on the same edge that publishes the flags, so the
  // totals seen alongside valid_out already include that word.
  always_comb begin
    w_sec_pop = '0;
    w_ded_pop = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_sec_pop = w_sec_pop + SUM_W'(w_dec_sec[k]);
      w_ded_pop = w_ded_pop + SUM_W'(w_dec_ded[k]);
    end
    w_corr_sum   = SUM_W'(r_corr_cnt) + w_sec_pop;
    w_uncorr_sum = SUM_W'(r_uncorr_cnt) + w_ded_pop;
    w_corr_nxt   = (w_corr_sum > SAT) ? SAT[CNT_W-1:0] : w_corr_sum[CNT_W-1:0];
    w_uncorr_nxt = (w_uncorr_sum > SAT) ? SAT[CNT_W-1:0] : w_uncorr_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_sec       <= '0;
      r_ded       <= '0;
    end else begin
      r_out_valid <= w_dec_valid;
      if (w_dec_valid) begin
        r_data_out <= w_dec_data;
        r_sec      <= w_dec_sec;
        r_ded      <= w_dec_ded;
      end else begin
        r_sec <= '0;
        r_ded <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_dec_valid) begin
      r_corr_cnt   <= w_corr_nxt;
      r_uncorr_cnt <= w_uncorr_nxt;
    end
  end

  assign valid_out  = r_out_valid;
  assign data_out   = r_data_out;
  assign sec_flag   = r_sec;
  assign ded_flag   = r_ded;
  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_secded_link_array.sv
module tb_secded_link_array;

  localparam int NCH = 4;
  localparam int LD  = 2;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [NCH*4-1:0]  data_in;
  logic [1:0]        inj_mode;
  logic [NCH-1:0]    inj_mask;
  logic [2:0]        inj_pos0;
  logic [2:0]        inj_pos1;
  logic              clr_cnt;
  logic              valid_out;
  logic [NCH*4-1:0]  data_out;
  logic [NCH-1:0]    sec_flag;
  logic [NCH-1:0]    ded_flag;
  logic [CW-1:0]     corr_cnt;
  logic [CW-1:0]     uncorr_cnt;

  secded_link_array #(
    .NUM_CH     (NCH),
    .LINK_DEPTH (LD),
    .CNT_W      (CW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .inj_mode   (inj_mode),
    .inj_mask   (inj_mask),
    .inj_pos0   (inj_pos0),
    .inj_pos1   (inj_pos1),
    .clr_cnt    (clr_cnt),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .sec_flag   (sec_flag),
    .ded_flag   (ded_flag),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*4-1:0] data;
    logic [NCH-1:0]   sec;
    logic [NCH-1:0]   ded;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference Hamming code: parity bit at position 2^k covers every data
  // position whose index has bit k set; bit 0 makes total parity even.
  function automatic logic [7:0] ref_enc(input logic [3:0] d);
    logic [7:0] cw;
    logic       p;
    cw = '0;
    cw[3] = d[0];
    cw[5] = d[1];
    cw[6] = d[2];
    cw[7] = d[3];
    for (int k = 0; k < 3; k++) begin
      p = 1'b0;
      for (int pos = 3; pos < 8; pos++) begin
        if ((pos & (1 << k)) != 0) p = p ^ cw[pos];
      end
      cw[1 << k] = p;
    end
    p = 1'b0;
    for (int pos = 1; pos < 8; pos++) p = p ^ cw[pos];
    cw[0] = p;
    return cw;
  endfunction

  // Outcome depends only on how many distinct bits were flipped.
  function automatic void model_lane(input logic [3:0] d, input logic [1:0] m, input bit en,
                                     input logic [2:0] p0, input logic [2:0] p1,
                                     output logic [3:0] od, output bit s, output bit dd);
    int         nerr;
    logic [7:0] cw;
    nerr = 0;
    if (en && m == 2'd1) nerr = 1;
    else if (en && m == 2'd2 && p0 != p1) nerr = 2;
    od = d;
    s  = (nerr == 1);
    dd = (nerr == 2);
    if (nerr == 2) begin
      cw = ref_enc(d);
      cw[p0] = ~cw[p0];
      cw[p1] = ~cw[p1];
      od = {cw[7], cw[6], cw[5], cw[3]};
    end
  endfunction

  task automatic drive(input bit v, input logic [NCH*4-1:0] d, input logic [1:0] m,
                       input logic [NCH-1:0] mask, input logic [2:0] p0, input logic [2:0] p1,
                       input bit clr);
    exp_t       e;
    logic [3:0] od;
    bit         s;
    bit         dd;
    @(posedge clk);
    #1;
    valid_in = v;
    data_in  = d;
    inj_mode = m;
    inj_mask = mask;
    inj_pos0 = p0;
    inj_pos1 = p1;
    clr_cnt  = clr;
    if (v) begin
      e.cyc = cyc;
      for (int k = 0; k < NCH; k++) begin
        model_lane(d[k*4 +: 4], m, mask[k], p0, p1, od, s, dd);
        e.data[k*4 +: 4] = od;
        e.sec[k] = s;
        e.ded[k] = dd;
      end
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 2'd0, '0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic rand_word(input bit clr);
    logic [2:0] p0;
    p0 = 3'($urandom_range(0, 7));
    drive(1'b1, (NCH*4)'($urandom), 2'($urandom_range(0, 3)), NCH'($urandom), p0,
          3'($urandom_range(0, 7)), clr);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    clr_cnt  = 1'b0;
    q.delete();
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_flags", 64'({sec_flag, ded_flag}), 64'd0);
    chk("rst_counters", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: clr_cnt is sampled at the active edge, outputs half a cycle later.
  logic [NCH*4-1:0] m_last = '0;
  int               m_corr = 0;
  int               m_unc  = 0;

  initial begin
    bit   l_clr;
    exp_t e;
    int   ps;
    int   pd;
    forever begin
      @(posedge clk);
      l_clr = clr_cnt;
      @(negedge clk);
      if (rst) begin
        m_corr = 0;
        m_unc  = 0;
        m_last = '0;
        chk("reset_valid", 64'(valid_out), 64'd0);
        chk("reset_data", 64'(data_out), 64'd0);
        chk("reset_cnt", 64'({corr_cnt, uncorr_cnt}), 64'd0);
      end else begin
        ps = 0;
        pd = 0;
        if (valid_out) begin
          if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_valid: got valid_out=1 data %0h expected no word", data_out);
          end else begin
            e = q.pop_front();
            chk("data_out", 64'(data_out), 64'(e.data));
            chk("sec_flag", 64'(sec_flag), 64'(e.sec));
            chk("ded_flag", 64'(ded_flag), 64'(e.ded));
            chk("latency", 64'(cyc - e.cyc), 64'(LD + 3));
            m_last = e.data;
            for (int k = 0; k < NCH; k++) begin
              ps += int'(e.sec[k]);
              pd += int'(e.ded[k]);
            end
          end
          if (l_clr) begin
            m_corr = 0;
            m_unc  = 0;
          end else begin
            m_corr = (m_corr + ps > CMAX) ? CMAX : m_corr + ps;
            m_unc  = (m_unc + pd > CMAX) ? CMAX : m_unc + pd;
          end
        end else begin
          chk("hold_data", 64'(data_out), 64'(m_last));
          chk("idle_flags", 64'({sec_flag, ded_flag}), 64'd0);
          if (l_clr) begin
            m_corr = 0;
            m_unc  = 0;
          end
        end
        chk("corr_cnt", 64'(corr_cnt), 64'(m_corr));
        chk("uncorr_cnt", 64'(uncorr_cnt), 64'(m_unc));
      end
    end
  end

  initial begin
    logic [2:0] p0;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    inj_mode = '0;
    inj_mask = '0;
    inj_pos0 = '0;
    inj_pos1 = '0;
    clr_cnt  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed words on lane 0 with random upper lanes.
    drive(1'b1, {12'($urandom), 4'b1011}, 2'd0, 4'b0000, 3'd0, 3'd0, 1'b0);
    drive(1'b1, {12'($urandom), 4'b1011}, 2'd1, 4'b0001, 3'd5, 3'd0, 1'b0);
    drive(1'b1, 16'($urandom), 2'd1, 4'b1111, 3'd0, 3'd0, 1'b0);
    drive(1'b1, {12'($urandom), 4'b1011}, 2'd2, 4'b0001, 3'd3, 3'd6, 1'b0);
    drive(1'b1, {12'($urandom), 4'b1011}, 2'd2, 4'b0001, 3'd3, 3'd3, 1'b0);
    drive(1'b1, 16'($urandom), 2'd3, 4'b1111, 3'd1, 3'd2, 1'b0);
    idle(8);

    // Drive both counters into saturation.
    repeat (70) drive(1'b1, 16'($urandom), 2'd1, 4'b1111, 3'($urandom_range(0, 7)), 3'd0, 1'b0);
    repeat (70) begin
      p0 = 3'($urandom_range(0, 7));
      drive(1'b1, 16'($urandom), 2'd2, 4'b1111, p0, p0 + 3'($urandom_range(1, 7)), 1'b0);
    end
    // Clear held while errors keep arriving, then release.
    repeat (8) drive(1'b1, 16'($urandom), 2'd1, 4'b1111, 3'd2, 3'd0, 1'b1);
    repeat (8) drive(1'b1, 16'($urandom), 2'd1, 4'b0101, 3'd6, 3'd0, 1'b0);

    // Random traffic with bubbles and occasional clears.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else rand_word($urandom_range(0, 24) == 0);
    end

    // Reset in the middle of a back-to-back stream.
    repeat (5) rand_word(1'b0);
    pulse_reset();
    repeat (5) rand_word(1'b0);
    idle(LD + 8);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
